// File: rtl/dmem_port_arbiter_if.sv
// Bundles the two requester ports, the external data-memory port and the
// status outputs of dmem_port_arbiter. The arbiter uses the slave view; the
// requesters/memory side (or a bench) uses the master view.
interface dmem_port_arbiter_if;
  // pipeline MEM stage (P)
  logic        p_req;
  logic        p_we;
  logic [31:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata;
  logic        p_done;
  logic        p_stall;
  // auxiliary master (A)
  logic        a_req;
  logic        a_we;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [31:0] a_rdata;
  logic        a_done;
  // data memory
  logic [31:0] d_address;
  logic [31:0] d_data_write;
  logic        d_write_enable;
  logic        d_read_enable;
  logic [31:0] d_data_read;
  logic        d_data_valid;
  // status
  logic        xfer_err;
  logic        timeout_sticky;

  modport slave (
    input  p_req, p_we, p_addr, p_wdata,
    output p_rdata, p_done, p_stall,
    input  a_req, a_we, a_addr, a_wdata,
    output a_rdata, a_done,
    output d_address, d_data_write, d_write_enable, d_read_enable,
    input  d_data_read, d_data_valid,
    output xfer_err, timeout_sticky
  );

  modport master (
    output p_req, p_we, p_addr, p_wdata,
    input  p_rdata, p_done, p_stall,
    output a_req, a_we, a_addr, a_wdata,
    input  a_rdata, a_done,
    input  d_address, d_data_write, d_write_enable, d_read_enable,
    output d_data_read, d_data_valid,
    input  xfer_err, timeout_sticky
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the pipeline MEM stage (P) and an
// auxiliary master (A). One transaction outstanding at a time, bounded
// fairness toward A, and hung accesses are aborted after TIMEOUT cycles.
//
// state  | meaning
// IDLE   | no access in flight; grant a pending request
// ACCESS | strobes driven from latched request; wait for d_data_valid
// DONE   | one-cycle done (and xfer_err) pulse to the owner; no grant
module dmem_port_arbiter #(
  parameter int unsigned MAX_P_BURST = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dmem_port_arbiter_if.slave    port_io
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_P_BURST);
  // ACCESS lasts exactly TIMEOUT cycles: the counter reads 0 in the first one
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  burst_q, burst_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        own_a_q, own_a_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p_rdata_q, p_rdata_d;
  logic [31:0] a_rdata_q, a_rdata_d;
  logic        p_done_q, p_done_d;
  logic        a_done_q, a_done_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic        grant_a;

  // A wins when P is silent, or when P has used up its burst while A waits
  assign grant_a = !port_io.p_req || (port_io.a_req && (burst_q == BURST_MAX));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    tmo_d     = tmo_q;
    own_a_d   = own_a_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    p_rdata_d = p_rdata_q;
    a_rdata_d = a_rdata_q;
    p_done_d  = 1'b0;
    a_done_d  = 1'b0;
    err_d     = 1'b0;
    sticky_d  = sticky_q;
    wen_d     = wen_q;
    ren_d     = ren_q;

    case (state_q)
      IDLE: begin
        if (port_io.p_req || port_io.a_req) begin
          state_d = ACCESS;
          tmo_d   = 8'd0;
          if (grant_a) begin
            own_a_d = 1'b1;
            we_d    = port_io.a_we;
            addr_d  = port_io.a_addr;
            wdata_d = port_io.a_wdata;
            burst_d = 4'd0;
            wen_d   = port_io.a_we;
            ren_d   = !port_io.a_we;
          end else begin
            own_a_d = 1'b0;
            we_d    = port_io.p_we;
            addr_d  = port_io.p_addr;
            wdata_d = port_io.p_wdata;
            if (!port_io.a_req)
              burst_d = 4'd0;
            else if (burst_q != BURST_MAX)
              burst_d = burst_q + 4'd1;
            wen_d   = port_io.p_we;
            ren_d   = !port_io.p_we;
          end
        end
      end

      ACCESS: begin
        tmo_d = tmo_q + 8'd1;
        if (port_io.d_data_valid || (tmo_q == TMO_LAST)) begin
          state_d = DONE;
          wen_d   = 1'b0;
          ren_d   = 1'b0;
          if (own_a_q) a_done_d = 1'b1;
          else         p_done_d = 1'b1;
          // valid wins over a timeout landing in the same cycle
          if (port_io.d_data_valid) begin
            if (own_a_q) a_rdata_d = we_q ? 32'd0 : port_io.d_data_read;
            else         p_rdata_d = we_q ? 32'd0 : port_io.d_data_read;
          end else begin
            if (own_a_q) a_rdata_d = 32'd0;
            else         p_rdata_d = 32'd0;
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        wen_d   = 1'b0;
        ren_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      burst_q   <= 4'd0;
      tmo_q     <= 8'd0;
      own_a_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      p_rdata_q <= 32'd0;
      a_rdata_q <= 32'd0;
      p_done_q  <= 1'b0;
      a_done_q  <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      tmo_q     <= tmo_d;
      own_a_q   <= own_a_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      p_rdata_q <= p_rdata_d;
      a_rdata_q <= a_rdata_d;
      p_done_q  <= p_done_d;
      a_done_q  <= a_done_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
    end
  end

  assign port_io.d_address      = addr_q;
  assign port_io.d_data_write   = wdata_q;
  assign port_io.d_write_enable = wen_q;
  assign port_io.d_read_enable  = ren_q;
  assign port_io.p_rdata        = p_rdata_q;
  assign port_io.p_done         = p_done_q;
  assign port_io.a_rdata        = a_rdata_q;
  assign port_io.a_done         = a_done_q;
  assign port_io.xfer_err       = err_q;
  assign port_io.timeout_sticky = sticky_q;
  // freeze the pipeline until the completion cycle so it advances on that edge
  assign port_io.p_stall        = port_io.p_req & ~p_done_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected
// completions, a monitor pops and compares on every done pulse.
module tb_dmem_port_arbiter;
  localparam int TMO = 8;

  typedef struct {
    bit          is_a;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];
  exp_t me;

  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(.MAX_P_BURST(4), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .port_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d_address"}, bus.d_address, 32'd0);
    chk({tag, "_d_data_write"}, bus.d_data_write, 32'd0);
    chk({tag, "_d_we"}, 32'(bus.d_write_enable), 32'd0);
    chk({tag, "_d_re"}, 32'(bus.d_read_enable), 32'd0);
    chk({tag, "_p_done"}, 32'(bus.p_done), 32'd0);
    chk({tag, "_a_done"}, 32'(bus.a_done), 32'd0);
    chk({tag, "_p_rdata"}, bus.p_rdata, 32'd0);
    chk({tag, "_a_rdata"}, bus.a_rdata, 32'd0);
    chk({tag, "_xfer_err"}, 32'(bus.xfer_err), 32'd0);
    chk({tag, "_sticky"}, 32'(bus.timeout_sticky), 32'd0);
  endtask

  // One transaction from the IDLE cycle N; lat=0 means memory never answers.
  // The requester scrambles addr/wdata during ACCESS to prove the latch holds.
  task automatic run_xfer(input bit is_a, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int lat, input logic [31:0] mem);
    int   n;
    int   dur;
    exp_t e;
    dur = (lat == 0) ? TMO : lat;
    if (is_a) begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.p_req = 1'b1; bus.p_we = we; bus.p_addr = addr; bus.p_wdata = wdata;
    end
    n       = cyc;
    e.is_a  = is_a;
    e.rdata = (we || lat == 0) ? 32'd0 : mem;
    e.err   = (lat == 0);
    e.cyc   = n + 1 + dur;
    sb.push_back(e);
    #1;
    chk("p_stall_req_cycle", 32'(bus.p_stall), 32'(!is_a));
    for (int k = 1; k <= dur; k++) begin
      tick();
      if (is_a) begin
        bus.a_addr = ~addr; bus.a_wdata = ~wdata;
      end else begin
        bus.p_addr = ~addr; bus.p_wdata = ~wdata;
      end
      chk("d_address_held", bus.d_address, addr);
      chk("d_data_write_held", bus.d_data_write, wdata);
      chk("d_write_enable", 32'(bus.d_write_enable), 32'(we));
      chk("d_read_enable", 32'(bus.d_read_enable), 32'(!we));
      if (!is_a) chk("p_stall_access", 32'(bus.p_stall), 32'd1);
      if (k == lat) begin
        bus.d_data_valid = 1'b1;
        bus.d_data_read  = mem;
      end
    end
    tick();
    bus.d_data_valid = 1'b0;
    bus.d_data_read  = 32'd0;
    chk("done_cycle_we", 32'(bus.d_write_enable), 32'd0);
    chk("done_cycle_re", 32'(bus.d_read_enable), 32'd0);
    if (!is_a) chk("p_stall_done_cycle", 32'(bus.p_stall), 32'd0);
    bus.p_req = 1'b0;
    bus.a_req = 1'b0;
    tick();
  endtask

  // Monitor: every done pulse must match the oldest expected completion
  always @(posedge clk) begin
    #2;
    if (bus.p_done || bus.a_done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done p_done=%0b a_done=%0b cycle=%0d", bus.p_done, bus.a_done, cyc);
      end else begin
        me = sb.pop_front();
        chk("done_owner_a", 32'(bus.a_done), 32'(me.is_a));
        chk("done_owner_p", 32'(bus.p_done), 32'(!me.is_a));
        chk("done_rdata", me.is_a ? bus.a_rdata : bus.p_rdata, me.rdata);
        chk("done_xfer_err", 32'(bus.xfer_err), 32'(me.err));
        chk("done_cycle", 32'(cyc), 32'(me.cyc));
      end
    end
  end

  initial begin
    bit [9:0]    order;
    bit          own;
    logic [31:0] dat;
    exp_t        e;

    cyc = 0; checks = 0; errors = 0;
    reset_n = 1'b0;
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_addr = 32'd0; bus.p_wdata = 32'd0;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 32'd0; bus.a_wdata = 32'd0;
    bus.d_data_read = 32'd0; bus.d_data_valid = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // single P read, L=1
    run_xfer(1'b0, 1'b0, 32'h0000_0100, 32'd0, 1, 32'hDEAD_BEEF);
    // P write, L=3
    run_xfer(1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 3, 32'hFFFF_FFFF);
    // A read that times out
    run_xfer(1'b1, 1'b0, 32'h0000_00A0, 32'd0, 0, 32'd0);
    chk("sticky_after_timeout", 32'(bus.timeout_sticky), 32'd1);
    // next P access completes normally, sticky stays set
    run_xfer(1'b0, 1'b0, 32'h0000_0104, 32'd0, 2, 32'hCAFE_F00D);
    chk("sticky_holds", 32'(bus.timeout_sticky), 32'd1);
    // A write, L=1
    run_xfer(1'b1, 1'b1, 32'h0000_0A04, 32'h5A5A_0001, 1, 32'h0BAD_0BAD);

    // contention: both requests held, expect P,P,P,P,A,P,P,P,P,A
    order = 10'b10_0001_0000;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h0000_0100;
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 32'h0000_0A00;
    for (int i = 0; i < 10; i++) begin
      own = order[i];
      tick();
      chk("grant_order", bus.d_address, own ? 32'h0000_0A00 : 32'h0000_0100);
      dat     = (own ? 32'hA0A0_0000 : 32'hB0B0_0000) + 32'(i);
      e.is_a  = own;
      e.rdata = dat;
      e.err   = 1'b0;
      e.cyc   = cyc + 1;
      sb.push_back(e);
      bus.d_data_valid = 1'b1;
      bus.d_data_read  = dat;
      tick();
      bus.d_data_valid = 1'b0;
      bus.d_data_read  = 32'd0;
      chk("no_back_to_back_re", 32'(bus.d_read_enable), 32'd0);
      if (i == 9) begin
        bus.p_req = 1'b0;
        bus.a_req = 1'b0;
      end
      tick();
    end

    // reset in the 2nd ACCESS cycle of an L=5 read
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_addr = 32'h0000_0300;
    tick();
    chk("pre_reset_re", 32'(bus.d_read_enable), 32'd1);
    tick();
    reset_n = 1'b0;
    bus.p_req = 1'b0;
    tick();
    chk_all_zero("mid_reset");
    reset_n = 1'b1;
    tick();
    bus.d_data_valid = 1'b1;
    bus.d_data_read  = 32'h5555_5555;
    tick();
    bus.d_data_valid = 1'b0;
    bus.d_data_read  = 32'd0;
    chk("late_valid_p_done", 32'(bus.p_done), 32'd0);
    chk("late_valid_re", 32'(bus.d_read_enable), 32'd0);
    tick();
    chk("late_valid_p_rdata", bus.p_rdata, 32'd0);
    run_xfer(1'b0, 1'b0, 32'h0000_0400, 32'd0, 1, 32'h0F0F_1234);

    repeat (4) tick();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
